// File: rtl/input_debounce_ctrl_pkg.sv
// Shared types and default constants for the input debounce controller.
// Holds the event FSM state encoding and the default timing parameters.
package input_debounce_ctrl_pkg;

    localparam int DEFAULT_PRESCALE     = 1000;
    localparam int DEFAULT_STABLE_COUNT = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } evt_state_t;

endpackage

// File: rtl/input_debounce_ctrl_debounce_channel.sv
// One debounced input: 2-flop synchronizer, tick-driven agreement counter and
// the accepted (stable) level. Pulses toggle on the edge where stable flips.
module debounce_channel
    import input_debounce_ctrl_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic toggle
);

    logic       sync_meta;
    logic       synced;
    logic [7:0] count;

    // The sample that completes the run flips stable and reports it in the same cycle.
    assign toggle = tick && (synced != stable) && (count == 8'(STABLE_COUNT - 1));

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= 1'b0;
            synced    <= 1'b0;
            count     <= '0;
            stable    <= 1'b0;
        end else begin
            sync_meta <= raw;
            synced    <= sync_meta;
            if (tick) begin
                if (synced == stable) begin
                    count <= '0;
                end else if (toggle) begin
                    count  <= '0;
                    stable <= ~stable;
                end else begin
                    count <= count + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/input_debounce_ctrl.sv
// Debounces N_INPUTS raw inputs on a shared sample tick and reports each
// accepted level change through a round-robin, ack-handshaked event port.
module input_debounce_ctrl
    import input_debounce_ctrl_pkg::*;
#(
    parameter  int N_INPUTS     = 4,
    parameter  int PRESCALE     = DEFAULT_PRESCALE,
    parameter  int STABLE_COUNT = DEFAULT_STABLE_COUNT,
    localparam int IDX_W        = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] in,
    output logic [N_INPUTS-1:0] stable,
    output logic                tick,
    output logic                event_valid,
    output logic [IDX_W-1:0]    event_index,
    output logic                event_level,
    input  logic                event_ack
);

    logic [15:0]         presc_cnt;
    logic [N_INPUTS-1:0] toggles;
    logic [N_INPUTS-1:0] pending;
    logic [N_INPUTS-1:0] pending_next;
    logic [N_INPUTS-1:0] clear_mask;
    logic [IDX_W-1:0]    pointer;
    logic [IDX_W-1:0]    sel_index;
    logic [IDX_W-1:0]    cand_idx;
    logic                sel_found;
    logic                retoggled;
    logic                load;
    logic                clear;
    evt_state_t          state;
    evt_state_t          state_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_cnt <= '0;
        end else if (presc_cnt == 16'(PRESCALE - 1)) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 16'd1;
        end
    end

    assign tick = (presc_cnt == 16'(PRESCALE - 1));

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_chan
        debounce_channel #(
            .STABLE_COUNT(STABLE_COUNT)
        ) u_chan (
            .clock (clock),
            .reset (reset),
            .tick  (tick),
            .raw   (in[g]),
            .stable(stable[g]),
            .toggle(toggles[g])
        );
    end

    // Round-robin: first pending channel scanning upward from the pointer, wrapping.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        sel_found = 1'b0;
        sel_index = '0;
        cand_idx  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            cand_idx = IDX_W'((int'(pointer) + i) % N_INPUTS);
            if (!sel_found && pending[cand_idx]) begin
                sel_found = 1'b1;
                sel_index = cand_idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        clear      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    load       = 1'b1;
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (event_ack) begin
                    clear      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A change on the presented channel after its level was captured must survive the ack.
    always_comb begin
        clear_mask = '0;
        if (clear && !retoggled) begin
            clear_mask[event_index] = 1'b1;
        end
        pending_next = (pending & ~clear_mask) | toggles;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            pending     <= '0;
            pointer     <= '0;
            retoggled   <= 1'b0;
            event_index <= '0;
            event_level <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (load) begin
                event_index <= sel_index;
                event_level <= stable[sel_index];
                retoggled   <= toggles[sel_index];
            end else if (state == ST_PRESENT && toggles[event_index]) begin
                retoggled <= 1'b1;
            end
            if (clear) begin
                pointer <= (event_index == IDX_W'(N_INPUTS - 1)) ? '0 : event_index + IDX_W'(1);
            end
        end
    end

    assign event_valid = (state == ST_PRESENT);

endmodule

// File: tb/tb_input_debounce_ctrl.sv
// Self-checking bench for input_debounce_ctrl (N_INPUTS=4, PRESCALE=4, STABLE_COUNT=4).
// Expected events are queued as stimulus is driven and matched as they are accepted.
module tb_input_debounce_ctrl;

    typedef struct {
        logic [1:0] idx;
        logic       lvl;
    } evt_t;

    logic       clock;
    logic       reset;
    logic [3:0] in;
    logic [3:0] stable;
    logic       tick;
    logic       event_valid;
    logic [1:0] event_index;
    logic       event_level;
    logic       event_ack;

    int   checks       = 0;
    int   failures     = 0;
    int   cyc          = 0;
    int   valid_cycles = 0;
    int   m_cnt        = 0;
    logic m_tick;
    evt_t sb_q[$];
    int   acc_q[$];
    evt_t exp_evt;

    input_debounce_ctrl #(
        .N_INPUTS    (4),
        .PRESCALE    (4),
        .STABLE_COUNT(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in         (in),
        .stable     (stable),
        .tick       (tick),
        .event_valid(event_valid),
        .event_index(event_index),
        .event_level(event_level),
        .event_ack  (event_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference sample-tick timing: one tick every fourth cycle after reset.
    always @(posedge clock) begin
        if (reset) m_cnt <= 0;
        else       m_cnt <= (m_cnt == 3) ? 0 : m_cnt + 1;
    end
    assign m_tick = (m_cnt == 3);

    task automatic monitor_proc();
        forever begin
            @(negedge clock);
            #1;
            cyc++;
            if (!reset && event_valid) valid_cycles++;
            if (!reset && event_valid && event_ack) begin
                acc_q.push_back(cyc);
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got index=%0d level=%0d, required no event",
                             event_index, event_level);
                end else begin
                    exp_evt = sb_q.pop_front();
                    if (event_index !== exp_evt.idx || event_level !== exp_evt.lvl) begin
                        failures++;
                        $display("FAIL event_match: got index=%0d level=%0d, required index=%0d level=%0d",
                                 event_index, event_level, exp_evt.idx, exp_evt.lvl);
                    end
                end
            end
        end
    endtask

    task automatic push_evt(input logic [1:0] idx, input logic lvl);
        evt_t e;
        e.idx = idx;
        e.lvl = lvl;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        in        = '0;
        event_ack = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    // Returns on the negedge of the n-th model tick, counting the current negedge.
    task automatic wait_ticks(input int n, input string tag);
        int seen = 0;
        for (int k = 0; k < 2000; k++) begin
            if (m_tick) begin
                seen++;
                if (seen == n) return;
            end
            @(negedge clock);
        end
        checks++;
        failures++;
        $display("FAIL %s_tick_timeout: got %0d ticks, required %0d", tag, seen, n);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d events outstanding, required 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (stable !== 4'b0000) begin failures++; $display("FAIL reset_stable: got %b required 0000", stable); end
        if (event_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", event_valid); end
        if (event_index !== 2'd0) begin failures++; $display("FAIL reset_index: got %0d required 0", event_index); end
        if (event_level !== 1'b0) begin failures++; $display("FAIL reset_level: got %b required 0", event_level); end
        if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b required 0", tick); end
    endtask

    task automatic test_prescaler();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            checks++;
            if (tick !== ((k % 4) == 3)) begin
                failures++;
                $display("FAIL prescaler_tick[%0d]: got %b required %b", k, tick, ((k % 4) == 3));
            end
            @(negedge clock);
        end
    endtask

    task automatic test_single_rise();
        do_reset();
        @(negedge clock);
        push_evt(2'd0, 1'b1);
        in[0] = 1'b1;
        repeat (2) @(negedge clock);
        wait_ticks(4, "single_rise");
        checks++;
        if (stable[0] !== 1'b0) begin failures++; $display("FAIL rise_before_accept: got %b required 0", stable[0]); end
        @(negedge clock);
        checks += 2;
        if (stable[0] !== 1'b1) begin failures++; $display("FAIL rise_stable: got %b required 1", stable[0]); end
        if (event_valid !== 1'b0) begin failures++; $display("FAIL rise_valid_early: got %b required 0", event_valid); end
        @(negedge clock);
        checks += 3;
        if (event_valid !== 1'b1) begin failures++; $display("FAIL rise_valid: got %b required 1", event_valid); end
        if (event_index !== 2'd0) begin failures++; $display("FAIL rise_index: got %0d required 0", event_index); end
        if (event_level !== 1'b1) begin failures++; $display("FAIL rise_level: got %b required 1", event_level); end
        event_ack = 1'b1;
        drain("single_rise");
        event_ack = 1'b0;
    endtask

    task automatic test_glitch();
        int vbase;
        do_reset();
        vbase = valid_cycles;
        @(negedge clock);
        in[1] = 1'b1;
        repeat (2) @(negedge clock);
        wait_ticks(3, "glitch");
        @(negedge clock);
        in[1] = 1'b0;
        repeat (30) @(negedge clock);
        checks += 2;
        if (stable[1] !== 1'b0) begin failures++; $display("FAIL glitch_stable: got %b required 0", stable[1]); end
        if (valid_cycles != vbase) begin
            failures++;
            $display("FAIL glitch_no_event: got %0d valid cycles required 0", valid_cycles - vbase);
        end
    endtask

    task automatic test_back_to_back();
        int abase;
        do_reset();
        event_ack = 1'b1;
        abase = acc_q.size();
        @(negedge clock);
        push_evt(2'd1, 1'b1);
        push_evt(2'd2, 1'b1);
        in[1] = 1'b1;
        in[2] = 1'b1;
        drain("back_to_back");
        checks++;
        if (acc_q.size() - abase != 2 || acc_q[abase+1] - acc_q[abase] != 2) begin
            failures++;
            $display("FAIL back_to_back_spacing: got %0d events gap %0d, required 2 events gap 2",
                     acc_q.size() - abase,
                     (acc_q.size() - abase >= 2) ? acc_q[abase+1] - acc_q[abase] : -1);
        end
        event_ack = 1'b0;
    endtask

    task automatic test_round_robin();
        int abase;
        do_reset();
        event_ack = 1'b1;
        @(negedge clock);
        push_evt(2'd2, 1'b1);
        in[2] = 1'b1;
        drain("rr_first");
        abase = acc_q.size();
        @(negedge clock);
        push_evt(2'd3, 1'b1);
        push_evt(2'd0, 1'b1);
        in[0] = 1'b1;
        in[3] = 1'b1;
        drain("rr_wrap");
        checks++;
        if (acc_q.size() - abase != 2) begin
            failures++;
            $display("FAIL rr_count: got %0d events required 2", acc_q.size() - abase);
        end
        event_ack = 1'b0;
    endtask

    task automatic test_withheld_ack();
        int abase;
        do_reset();
        @(negedge clock);
        push_evt(2'd3, 1'b1);
        in[3] = 1'b1;
        repeat (2) @(negedge clock);
        wait_ticks(5, "withheld_rise");
        checks += 3;
        if (event_valid !== 1'b1) begin failures++; $display("FAIL withheld_valid: got %b required 1", event_valid); end
        if (event_index !== 2'd3) begin failures++; $display("FAIL withheld_index: got %0d required 3", event_index); end
        if (event_level !== 1'b1) begin failures++; $display("FAIL withheld_level: got %b required 1", event_level); end
        @(negedge clock);
        push_evt(2'd3, 1'b0);
        in[3] = 1'b0;
        repeat (2) @(negedge clock);
        wait_ticks(5, "withheld_fall");
        checks += 3;
        if (stable[3] !== 1'b0) begin failures++; $display("FAIL withheld_stable_fell: got %b required 0", stable[3]); end
        if (event_valid !== 1'b1) begin failures++; $display("FAIL withheld_still_valid: got %b required 1", event_valid); end
        if (event_level !== 1'b1) begin failures++; $display("FAIL withheld_level_held: got %b required 1", event_level); end
        abase = acc_q.size();
        event_ack = 1'b1;
        drain("withheld");
        checks++;
        if (acc_q.size() - abase != 2 || acc_q[abase+1] - acc_q[abase] != 2) begin
            failures++;
            $display("FAIL withheld_second_event: got %0d events, required 2 events 2 cycles apart",
                     acc_q.size() - abase);
        end
        event_ack = 1'b0;
    endtask

    task automatic test_reset_midcount();
        int vbase;
        do_reset();
        vbase = valid_cycles;
        @(negedge clock);
        in[0] = 1'b1;
        repeat (2) @(negedge clock);
        wait_ticks(3, "midcount_pre");
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        wait_ticks(3, "midcount_post3");
        @(negedge clock);
        checks++;
        if (stable[0] !== 1'b0) begin failures++; $display("FAIL midcount_after3: got %b required 0", stable[0]); end
        wait_ticks(1, "midcount_post4");
        @(negedge clock);
        checks += 2;
        if (stable[0] !== 1'b1) begin failures++; $display("FAIL midcount_after4: got %b required 1", stable[0]); end
        if (valid_cycles != vbase) begin
            failures++;
            $display("FAIL midcount_no_event: got %0d valid cycles required 0", valid_cycles - vbase);
        end
        push_evt(2'd0, 1'b1);
        event_ack = 1'b1;
        drain("midcount");
        event_ack = 1'b0;
    endtask

    task automatic test_reset_present();
        int vbase;
        do_reset();
        event_ack = 1'b1;
        repeat (5) @(negedge clock);
        event_ack = 1'b0;
        in[2] = 1'b1;
        repeat (2) @(negedge clock);
        wait_ticks(4, "present");
        repeat (2) @(negedge clock);
        checks += 2;
        if (event_valid !== 1'b1) begin failures++; $display("FAIL present_valid: got %b required 1", event_valid); end
        if (event_index !== 2'd2) begin failures++; $display("FAIL present_index: got %0d required 2", event_index); end
        do_reset();
        checks += 2;
        if (event_valid !== 1'b0) begin failures++; $display("FAIL present_reset_valid: got %b required 0", event_valid); end
        if (event_index !== 2'd0) begin failures++; $display("FAIL present_reset_index: got %0d required 0", event_index); end
        vbase = valid_cycles;
        event_ack = 1'b1;
        repeat (30) @(negedge clock);
        event_ack = 1'b0;
        checks++;
        if (valid_cycles != vbase) begin
            failures++;
            $display("FAIL present_discarded: got %0d valid cycles required 0", valid_cycles - vbase);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in        = '0;
        event_ack = 1'b0;
        fork
            monitor_proc();
        join_none
        test_reset();
        test_prescaler();
        test_single_rise();
        test_glitch();
        test_back_to_back();
        test_round_robin();
        test_withheld_ack();
        test_reset_midcount();
        test_reset_present();
        repeat (4) @(negedge clock);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue: got %0d outstanding required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
